// File: rtl/ext_loader_pkg.sv
// Shared types and constants for the external memory loader.
package ext_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] RESET_ADDR     = 32'h0000_0000;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler shared by the length, data and checksum phases.
module word_assembler
  import ext_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  // Only the earlier bytes are stored; the final byte is merged combinationally.
  logic [23:0]     word_q, word_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (accept_i) begin
      word_d = {byte_i, word_q[23:8]};
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o     = {byte_i, word_q};
  assign complete_o = accept_i && !clear_i && (idx_q == LastIdx);

endmodule

// File: rtl/ext_mem_loader.sv
// Streams a length-prefixed word image from a byte host into data memory while holding the CPU.
// Optional trailing checksum phase enabled by defining LOADER_CHECKSUM_EN.
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_ADDR,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FinishSt = StChk;
`else
  localparam state_e FinishSt = StDone;
`endif
  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] n_q, n_d;
  logic [31:0] cnt_q, cnt_d;
  logic        in_ready_q, mem_write_q, hold_q, done_q, err_q;
  logic        asm_clear, asm_done;
  logic [31:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  word_assembler u_word_assembler (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (asm_clear),
    .accept_i   (in_valid && in_ready_q),
    .byte_i     (in_data),
    .word_o     (asm_word),
    .complete_o (asm_done)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    asm_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d   = StLen;
          addr_d    = BASE_ADDR;
          n_d       = '0;
          cnt_d     = '0;
          asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      StLen: begin
        if (asm_done) begin
          n_d = asm_word;
          if (asm_word == '0)         state_d = FinishSt;
          else if (asm_word > MaxWords) state_d = StErr;
          else                        state_d = StData;
        end
      end
      StData: begin
        if (asm_done) begin
          wdata_d = asm_word;
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        state_d = (cnt_q + 32'd1 == n_q) ? FinishSt : StData;
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (asm_done) state_d = (asm_word == sum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align exactly with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_write_q <= 1'b0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= state_d inside {StLen, StData, StChk};
      mem_write_q <= (state_d == StWrite);
      hold_q      <= (state_d != StDone);
      done_q      <= (state_d == StDone);
      err_q       <= (state_d == StErr);
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_DataAdr   = addr_q;
  assign Ext_WriteData = wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
